// File: rtl/musb_defines.sv
// Shared encodings for the load/store unit: FSM states, access sizes and
// byte-lane write masks (big-endian, lane 0 = bits 31:24).
package musb_defines;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'd0,
    LSU_BUSY = 2'd1,
    LSU_DONE = 2'd2
  } lsu_state_t;

  typedef enum logic [1:0] {
    SIZE_WORD = 2'd0,
    SIZE_HALF = 2'd1,
    SIZE_BYTE = 2'd2
  } lsu_size_t;

  localparam logic [3:0] LANE_WORD    = 4'b1111;
  localparam logic [3:0] LANE_HALF_HI = 4'b1100;
  localparam logic [3:0] LANE_HALF_LO = 4'b0011;
  localparam logic [3:0] LANE_BYTE_0  = 4'b1000;

  // Byte wins if both size bits are set; neither means a full word.
  function automatic lsu_size_t decode_size(input logic is_byte, input logic is_half);
    if (is_byte)
      return SIZE_BYTE;
    else if (is_half)
      return SIZE_HALF;
    else
      return SIZE_WORD;
  endfunction

endpackage

// File: rtl/musb_lsu_data_format.sv
// Combinational lane logic: store replication and write enables, misalignment
// detection for the live request, and load extraction/extension of bus data.
module musb_lsu_data_format
  import musb_defines::*;
(
  input  lsu_size_t   req_size,
  input  logic [1:0]  req_offset,
  input  logic [31:0] store_data,
  output logic [3:0]  store_mask,
  output logic [31:0] store_lanes,
  output logic        misaligned,
  input  lsu_size_t   load_size,
  input  logic [1:0]  load_offset,
  input  logic        load_sign,
  input  logic [31:0] load_word,
  output logic [31:0] load_data
);

  logic [7:0]  load_byte;
  logic [15:0] load_half;

  always_comb begin
    store_mask  = LANE_WORD;
    store_lanes = store_data;
    misaligned  = 1'b0;
    case (req_size)
      SIZE_BYTE: begin
        store_mask  = LANE_BYTE_0 >> req_offset;
        store_lanes = {4{store_data[7:0]}};
      end
      SIZE_HALF: begin
        store_mask  = req_offset[1] ? LANE_HALF_LO : LANE_HALF_HI;
        store_lanes = {2{store_data[15:0]}};
        misaligned  = req_offset[0];
      end
      default: misaligned = |req_offset;
    endcase
  end

  // Offset 0 addresses the most significant byte.
  always_comb begin
    load_byte = load_word[31:24];
    case (load_offset)
      2'd0: load_byte = load_word[31:24];
      2'd1: load_byte = load_word[23:16];
      2'd2: load_byte = load_word[15:8];
      2'd3: load_byte = load_word[7:0];
    endcase
    load_half = load_offset[1] ? load_word[15:0] : load_word[31:16];
    load_data = load_word;
    case (load_size)
      SIZE_BYTE: load_data = {{24{load_sign & load_byte[7]}}, load_byte};
      SIZE_HALF: load_data = {{16{load_sign & load_half[15]}}, load_half};
      default:   load_data = load_word;
    endcase
  end

endmodule

// File: rtl/musb_load_store_unit.sv
// MEM-stage data-port initiator: launches one bus transfer per aligned access,
// stalls the pipeline until it completes, and formats load data for MEM/WB.
module musb_load_store_unit
  import musb_defines::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] mem_address,
  input  logic [31:0] mem_write_data,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic        mem_byte,
  input  logic        mem_halfword,
  input  logic        mem_sign_extend,
  input  logic        mem_flush,
  input  logic        pipe_stall,
  output logic [31:0] mem_read_data,
  output logic        mem_stall,
  output logic        exc_address_load,
  output logic        exc_address_store,
  output logic        exc_bus_error,
  output logic [31:0] dport_address,
  output logic [31:0] dport_data_o,
  output logic [3:0]  dport_wr,
  output logic        dport_enable,
  input  logic [31:0] dport_data_i,
  input  logic        dport_ready,
  input  logic        dport_error
);

  lsu_state_t  state_reg, state_next;
  lsu_size_t   req_size, ld_size_reg;
  logic [1:0]  ld_offset_reg;
  logic        ld_sign_reg, ld_is_load_reg;
  logic [3:0]  store_mask;
  logic [31:0] store_lanes, load_data;
  logic        misaligned, access, aligned_access, in_idle, in_busy;

  assign req_size       = decode_size(mem_byte, mem_halfword);
  assign access         = (mem_read | mem_write) & ~mem_flush;
  assign aligned_access = access & ~misaligned;
  assign in_idle        = (state_reg == LSU_IDLE);
  assign in_busy        = (state_reg == LSU_BUSY);

  assign mem_stall         = (in_idle & aligned_access) | in_busy;
  assign exc_address_load  = in_idle & access & misaligned & mem_read;
  assign exc_address_store = in_idle & access & misaligned & mem_write;

  // Load formatting uses the captured request, since the bus answers later.
  musb_lsu_data_format u_format (
    .req_size    (req_size),
    .req_offset  (mem_address[1:0]),
    .store_data  (mem_write_data),
    .store_mask  (store_mask),
    .store_lanes (store_lanes),
    .misaligned  (misaligned),
    .load_size   (ld_size_reg),
    .load_offset (ld_offset_reg),
    .load_sign   (ld_sign_reg),
    .load_word   (dport_data_i),
    .load_data   (load_data)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      state_reg <= LSU_IDLE;
    else
      state_reg <= state_next;
  end

  // DONE waits for the pipeline to take the instruction so it is not relaunched.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      LSU_IDLE: if (aligned_access) state_next = LSU_BUSY;
      LSU_BUSY: if (dport_ready)    state_next = LSU_DONE;
      LSU_DONE: if (!pipe_stall)    state_next = LSU_IDLE;
      default:  state_next = LSU_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dport_address  <= '0;
      dport_data_o   <= '0;
      dport_wr       <= '0;
      dport_enable   <= 1'b0;
      mem_read_data  <= '0;
      exc_bus_error  <= 1'b0;
      ld_size_reg    <= SIZE_WORD;
      ld_offset_reg  <= '0;
      ld_sign_reg    <= 1'b0;
      ld_is_load_reg <= 1'b0;
    end else begin
      exc_bus_error <= 1'b0;
      if (in_idle && aligned_access) begin
        dport_address  <= {mem_address[31:2], 2'b00};
        dport_data_o   <= store_lanes;
        dport_wr       <= mem_write ? store_mask : 4'b0000;
        dport_enable   <= 1'b1;
        ld_size_reg    <= req_size;
        ld_offset_reg  <= mem_address[1:0];
        ld_sign_reg    <= mem_sign_extend;
        ld_is_load_reg <= mem_read & ~mem_write;
      end
      if (in_busy && dport_ready) begin
        dport_enable  <= 1'b0;
        exc_bus_error <= dport_error;
        if (ld_is_load_reg)
          mem_read_data <= dport_error ? 32'd0 : load_data;
      end
    end
  end

endmodule
